alu32: RTL and testbench

- Registered WIDTH-bit integer ALU for the course single-cycle/multi-cycle CPU datapath.
- Performs one of eight operations selected by a 3-bit opcode on operands A and B.
- Registers the result C and a Zero flag one clock after the inputs are sampled.
- Zero feeds branch-decision logic.

---
 rtl/alu32.sv | 95 +++++++++
 tb/tb_alu32.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu32.sv
// alu32: registered WIDTH-bit integer ALU with eight operations and a Zero flag.
// Optional Overflow output (signed ADD/SUB) when ALU_OVERFLOW_EN is defined.
module alu32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic [WIDTH-1:0] C,
  output logic             Zero
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } op_e;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_shamt;
  logic             w_lt;
  logic [WIDTH-1:0] w_result;

  assign w_sum   = A + B;
  assign w_diff  = A - B;
  assign w_shamt = B[SHW-1:0];
  assign w_lt    = ($signed(A) < $signed(B));

  // Combinational result select; default branch is unreachable and behaves as ADD
  always_comb begin
    w_result = w_sum;
    case (op_e'(ALUOp))
      OP_ADD:  w_result = w_sum;
      OP_SUB:  w_result = w_diff;
      OP_AND:  w_result = A & B;
      OP_OR:   w_result = A | B;
      OP_XOR:  w_result = A ^ B;
      OP_SLT:  w_result = WIDTH'(w_lt);
      OP_SLL:  w_result = A << w_shamt;
      OP_SRL:  w_result = A >> w_shamt;
      default: w_result = w_sum;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  logic w_ovf;

  // Signed overflow: ADD when like-signed operands give an unlike-signed sum,
  // SUB when unlike-signed operands give a result whose sign differs from A
  always_comb begin
    w_ovf = 1'b0;
    case (op_e'(ALUOp))
      OP_ADD:  w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      OP_SUB:  w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      default: w_ovf = 1'b0;
    endcase
  end

  // Overflow register, captured in lockstep with C
  always_ff @(posedge clk) begin
    if (rst) begin
      Overflow <= 1'b0;
    end else if (en) begin
      Overflow <= w_ovf;
    end
  end
`endif

  // Result and Zero registers; reset wins over enable, en=0 holds both
  always_ff @(posedge clk) begin
    if (rst) begin
      C    <= '0;
      Zero <= 1'b1;
    end else if (en) begin
      C    <= w_result;
      Zero <= (w_result == '0);
    end
  end

endmodule

// File: tb/tb_alu32.sv
// tb_alu32: self-checking bench for alu32 with directed cases and a random
// stream checked against a behavioural model. Define ALU_OVERFLOW_EN to also
// exercise the Overflow output.
module tb_alu32;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALUOp;
  logic [WIDTH-1:0] C;
  logic             Zero;
`ifdef ALU_OVERFLOW_EN
  logic             Overflow;
`endif

  int errors;
  int checks;

  alu32 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .A     (A),
    .B     (B),
    .ALUOp (ALUOp),
    .C     (C),
    .Zero  (Zero)
`ifdef ALU_OVERFLOW_EN
    ,
    .Overflow (Overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from the arithmetic meaning of each opcode
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned p;
    int sh;
    ua = longint'(a);
    ub = longint'(b);
    sh = int'(b % 32);
    p  = 64'd1 << sh;
    case (op)
      3'd0: ref_alu = 32'((ua + ub) % 64'h1_0000_0000);
      3'd1: ref_alu = 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      3'd2: ref_alu = a & b;
      3'd3: ref_alu = a | b;
      3'd4: ref_alu = a ^ b;
      3'd5: ref_alu = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      3'd6: ref_alu = 32'((ua * p) % 64'h1_0000_0000);
      default: ref_alu = 32'(ua / p);
    endcase
  endfunction

  // Reference overflow: true signed result falls outside the 32-bit range
  function automatic logic ref_ovf(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    longint sa;
    longint sb;
    longint r;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    if (op == 3'd0) r = sa + sb;
    else if (op == 3'd1) r = sa - sb;
    else r = 0;
    ref_ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Apply one cycle of inputs on the falling edge; return 1ns after the rising edge
  task automatic drive(input logic r, input logic e, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst   = r;
    en    = e;
    ALUOp = op;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 3'd0, 32'd9, 32'd9);
    drive(1'b1, 1'b1, 3'd0, 32'd9, 32'd9);
    checks++;
    if (C !== 32'd0) begin errors++; $display("FAIL reset_c: got %h want %h", C, 32'd0); end
    checks++;
    if (Zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", Zero); end
`ifdef ALU_OVERFLOW_EN
    checks++;
    if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", Overflow); end
`endif
    drive(1'b0, 1'b0, 3'd0, 32'd3, 32'd4);
    checks++;
    if (C !== 32'd0 || Zero !== 1'b1) begin
      errors++; $display("FAIL reset_hold: got C=%h Z=%b want C=0 Z=1", C, Zero);
    end
  endtask

  task automatic test_opcode_sweep();
    logic [31:0] exp_tab [8];
    exp_tab[0] = 32'd15;         exp_tab[1] = 32'hFFFF_FFF5;
    exp_tab[2] = 32'd0;          exp_tab[3] = 32'd15;
    exp_tab[4] = 32'd15;         exp_tab[5] = 32'd1;
    exp_tab[6] = 32'h0000_4000;  exp_tab[7] = 32'd0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 3'(i), 32'd2, 32'd13);
      checks++;
      if (C !== exp_tab[i] || Zero !== (exp_tab[i] == 32'd0)) begin
        errors++;
        $display("FAIL sweep_op%0d: got C=%h Z=%b want C=%h Z=%b", i, C, Zero,
                 exp_tab[i], (exp_tab[i] == 32'd0));
      end
    end
  endtask

  task automatic test_signed_wrap();
    drive(1'b0, 1'b1, 3'd5, 32'h8000_0000, 32'h7FFF_FFFF);
    checks++;
    if (C !== 32'd1 || Zero !== 1'b0) begin
      errors++; $display("FAIL slt_signed: got C=%h Z=%b want C=1 Z=0", C, Zero);
    end
    drive(1'b0, 1'b1, 3'd5, 32'd5, 32'd5);
    checks++;
    if (C !== 32'd0 || Zero !== 1'b1) begin
      errors++; $display("FAIL slt_equal: got C=%h Z=%b want C=0 Z=1", C, Zero);
    end
    drive(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1);
    checks++;
    if (C !== 32'd0 || Zero !== 1'b1) begin
      errors++; $display("FAIL add_wrap: got C=%h Z=%b want C=0 Z=1", C, Zero);
    end
  endtask

  task automatic test_shift_bounds();
    drive(1'b0, 1'b1, 3'd6, 32'd1, 32'd31);
    checks++;
    if (C !== 32'h8000_0000) begin errors++; $display("FAIL sll_max: got %h want 80000000", C); end
    drive(1'b0, 1'b1, 3'd7, 32'h8000_0000, 32'h0000_003F);
    checks++;
    if (C !== 32'd1) begin errors++; $display("FAIL srl_mask: got %h want 00000001", C); end
    drive(1'b0, 1'b1, 3'd6, 32'd7, 32'd0);
    checks++;
    if (C !== 32'd7) begin errors++; $display("FAIL sll_zero: got %h want 00000007", C); end
  endtask

  task automatic test_enable_reset();
    drive(1'b0, 1'b1, 3'd0, 32'd2, 32'd13);
    checks++;
    if (C !== 32'd15) begin errors++; $display("FAIL en_compute: got %h want 0000000f", C); end
    drive(1'b0, 1'b0, 3'd0, 32'd1, 32'd1);
    checks++;
    if (C !== 32'd15 || Zero !== 1'b0) begin
      errors++; $display("FAIL en_hold: got C=%h Z=%b want C=f Z=0", C, Zero);
    end
    drive(1'b1, 1'b1, 3'd0, 32'd1, 32'd1);
    checks++;
    if (C !== 32'd0 || Zero !== 1'b1) begin
      errors++; $display("FAIL rst_priority: got C=%h Z=%b want C=0 Z=1", C, Zero);
    end
    drive(1'b0, 1'b1, 3'd1, 32'd10, 32'd3);
    checks++;
    if (C !== 32'd7) begin errors++; $display("FAIL post_reset: got %h want 00000007", C); end
  endtask

`ifdef ALU_OVERFLOW_EN
  task automatic test_overflow();
    drive(1'b0, 1'b1, 3'd0, 32'h7FFF_FFFF, 32'd1);
    checks++;
    if (C !== 32'h8000_0000 || Overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_add: got C=%h O=%b want C=80000000 O=1", C, Overflow);
    end
    drive(1'b0, 1'b1, 3'd1, 32'h8000_0000, 32'd1);
    checks++;
    if (C !== 32'h7FFF_FFFF || Overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sub: got C=%h O=%b want C=7fffffff O=1", C, Overflow);
    end
    drive(1'b0, 1'b1, 3'd2, 32'h8000_0000, 32'd1);
    checks++;
    if (Overflow !== 1'b0) begin errors++; $display("FAIL ovf_and: got %b want 0", Overflow); end
    drive(1'b0, 1'b0, 3'd0, 32'h7FFF_FFFF, 32'd1);
    checks++;
    if (Overflow !== 1'b0) begin errors++; $display("FAIL ovf_hold: got %b want 0", Overflow); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] exp_c;
    logic        exp_z;
    logic        exp_o;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        r;
    logic        e;
    exp_c = C;
    exp_z = Zero;
    exp_o = 1'b0;
`ifdef ALU_OVERFLOW_EN
    exp_o = Overflow;
`endif
    for (int i = 0; i < 400; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = 3'($urandom_range(0, 7));
      r  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: b = a;
        1: b = 32'($urandom_range(0, 40));
        2: a = {a[31], 31'h7FFF_FFF0} | 32'($urandom_range(0, 15));
        default: ;
      endcase
      drive(r, e, op, a, b);
      if (r) begin
        exp_c = 32'd0; exp_z = 1'b1; exp_o = 1'b0;
      end else if (e) begin
        exp_c = ref_alu(op, a, b);
        exp_z = (exp_c == 32'd0);
        exp_o = ref_ovf(op, a, b);
      end
      checks++;
      if (C !== exp_c || Zero !== exp_z) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got C=%h Z=%b want C=%h Z=%b",
                 i, op, a, b, C, Zero, exp_c, exp_z);
      end
`ifdef ALU_OVERFLOW_EN
      checks++;
      if (Overflow !== exp_o) begin
        errors++;
        $display("FAIL random_ovf_%0d op=%0d a=%h b=%h: got %b want %b",
                 i, op, a, b, Overflow, exp_o);
      end
`endif
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    en     = 1'b0;
    ALUOp  = 3'd0;
    A      = '0;
    B      = '0;
    test_reset();
    test_opcode_sweep();
    test_signed_wrap();
    test_shift_bounds();
    test_enable_reset();
`ifdef ALU_OVERFLOW_EN
    test_overflow();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
